// File: rtl/aes_v3_mix_seq_if.sv
// aes_v3_mix_seq_if
// Request/response bundle between the core's crypto functional-unit slot
// and the multi-cycle MixColumns unit.
//   valid : request valid, held by the core until ready (dropping it aborts)
//   rs1   : source register 1, bytes a0 = rs1[7:0], a1 = rs1[15:8]
//   rs2   : source register 2, bytes a2 = rs2[23:16], a3 = rs2[31:24]
//   enc   : 1 = forward MixColumns, 0 = inverse
//   ready : single-cycle result-valid pulse
//   rd    : result column {r3,r2,r1,r0}
interface aes_v3_mix_seq_if;
  logic        valid;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        enc;
  logic        ready;
  logic [31:0] rd;

  modport master (output valid, rs1, rs2, enc, input ready, rd);
  modport slave  (input valid, rs1, rs2, enc, output ready, rd);
endinterface

// File: rtl/aes_v3_mix_seq.sv
// aes_v3_mix_seq
// Multi-cycle forward/inverse AES MixColumns of one 32-bit column.
// LANES output bytes are produced per BUSY cycle (1, 2 or 4); DEC_EN=0
// removes the inverse datapath so enc=0 computes the forward transform.
// Ports:
//   g_clk    : clock, rising edge
//   g_resetn : asynchronous active-low reset
//   bus      : slave side of aes_v3_mix_seq_if (valid/rs1/rs2/enc in,
//              ready/rd out)
module aes_v3_mix_seq #(
  parameter int LANES  = 1,
  parameter int DEC_EN = 1
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  aes_v3_mix_seq_if.slave   bus
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_lanes_check
    $error("aes_v3_mix_seq: LANES must be 1, 2 or 4");
  end

  localparam logic [2:0] LANES3 = 3'(LANES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] op_q, op_d;
  logic        enc_q, enc_d;
  logic [31:0] res_q, res_d;
  logic [2:0]  cnt_next;
  logic [1:0]  lane_idx;
  logic        use_inv;
  logic        unused_bits;

  assign unused_bits = ^{bus.rs1[31:16], bus.rs2[15:0]};

  // Inverse is only honoured when the decrypt datapath is built in.
  assign use_inv = (DEC_EN != 0) && !enc_q;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Output byte k: rotate the column so that a_k lands in byte 0, then
  // apply the fixed coefficient row to bytes 0..3 of the rotated word.
  function automatic logic [7:0] lane_byte(input logic [31:0] col,
                                           input logic [1:0]  k,
                                           input logic        inv);
    logic [31:0] rot;
    logic [7:0]  b0, b1, b2, b3;
    logic [7:0]  b0x2, b0x4, b0x8, b1x2, b1x4, b1x8;
    logic [7:0]  b2x2, b2x4, b2x8, b3x2, b3x4, b3x8;
    case (k)
      2'd0:    rot = col;
      2'd1:    rot = {col[7:0],  col[31:8]};
      2'd2:    rot = {col[15:0], col[31:16]};
      default: rot = {col[23:0], col[31:24]};
    endcase
    b0 = rot[7:0];
    b1 = rot[15:8];
    b2 = rot[23:16];
    b3 = rot[31:24];
    b0x2 = xt(b0); b0x4 = xt(b0x2); b0x8 = xt(b0x4);
    b1x2 = xt(b1); b1x4 = xt(b1x2); b1x8 = xt(b1x4);
    b2x2 = xt(b2); b2x4 = xt(b2x2); b2x8 = xt(b2x4);
    b3x2 = xt(b3); b3x4 = xt(b3x2); b3x8 = xt(b3x4);
    if (inv) begin
      // 0e*b0 ^ 0b*b1 ^ 0d*b2 ^ 09*b3
      return (b0x8 ^ b0x4 ^ b0x2) ^ (b1x8 ^ b1x2 ^ b1) ^
             (b2x8 ^ b2x4 ^ b2) ^ (b3x8 ^ b3);
    end
    // 02*b0 ^ 03*b1 ^ b2 ^ b3
    return b0x2 ^ (b1x2 ^ b1) ^ b2 ^ b3;
  endfunction

  // Next-state and output logic. ready depends only on state and valid.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    enc_d     = enc_q;
    res_d     = res_q;
    lane_idx  = 2'd0;
    bus.ready = 1'b0;
    cnt_next  = {1'b0, cnt_q} + LANES3;
    case (state_q)
      IDLE: begin
        if (bus.valid) begin
          op_d    = {bus.rs2[31:16], bus.rs1[15:0]};
          enc_d   = bus.enc;
          res_d   = 32'h0;
          cnt_d   = 2'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Abort leaves the partially written result untouched.
        if (!bus.valid) begin
          state_d = IDLE;
        end else begin
          for (int l = 0; l < LANES; l++) begin
            lane_idx = cnt_q + 2'(l);
            res_d[{lane_idx, 3'b000} +: 8] = lane_byte(op_q, lane_idx, use_inv);
          end
          cnt_d = cnt_next[1:0];
          if (cnt_next == 3'd4) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        bus.ready = bus.valid;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, operand and result registers.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      op_q    <= 32'h0;
      enc_q   <= 1'b0;
      res_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      enc_q   <= enc_d;
      res_q   <= res_d;
    end
  end

  assign bus.rd = res_q;

endmodule

// File: tb/tb_aes_v3_mix_seq.sv
// tb_aes_v3_mix_seq
// Directed and randomised checks of aes_v3_mix_seq. Four instances share
// one request stream: index 0 = LANES 1, 1 = LANES 2, 2 = LANES 4
// (all with DEC_EN 1), 3 = LANES 1 with DEC_EN 0. Each test observes
// only the instance it targets; idle cycles with valid low return every
// instance to IDLE between tests.
module tb_aes_v3_mix_seq;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] rs1 = 32'h0;
  logic [31:0] rs2 = 32'h0;
  logic        enc = 1'b0;

  int vectors = 0;
  int errors  = 0;

  always #5 g_clk = ~g_clk;

  aes_v3_mix_seq_if bus0 ();
  aes_v3_mix_seq_if bus1 ();
  aes_v3_mix_seq_if bus2 ();
  aes_v3_mix_seq_if bus3 ();

  assign bus0.valid = valid; assign bus0.rs1 = rs1; assign bus0.rs2 = rs2; assign bus0.enc = enc;
  assign bus1.valid = valid; assign bus1.rs1 = rs1; assign bus1.rs2 = rs2; assign bus1.enc = enc;
  assign bus2.valid = valid; assign bus2.rs1 = rs1; assign bus2.rs2 = rs2; assign bus2.enc = enc;
  assign bus3.valid = valid; assign bus3.rs1 = rs1; assign bus3.rs2 = rs2; assign bus3.enc = enc;

  aes_v3_mix_seq #(.LANES(1), .DEC_EN(1)) u_dut0 (.g_clk(g_clk), .g_resetn(g_resetn), .bus(bus0));
  aes_v3_mix_seq #(.LANES(2), .DEC_EN(1)) u_dut1 (.g_clk(g_clk), .g_resetn(g_resetn), .bus(bus1));
  aes_v3_mix_seq #(.LANES(4), .DEC_EN(1)) u_dut2 (.g_clk(g_clk), .g_resetn(g_resetn), .bus(bus2));
  aes_v3_mix_seq #(.LANES(1), .DEC_EN(0)) u_dut3 (.g_clk(g_clk), .g_resetn(g_resetn), .bus(bus3));

  logic        rdy [4];
  logic [31:0] rdv [4];
  assign rdy[0] = bus0.ready; assign rdv[0] = bus0.rd;
  assign rdy[1] = bus1.ready; assign rdv[1] = bus1.rd;
  assign rdy[2] = bus2.ready; assign rdv[2] = bus2.rd;
  assign rdy[3] = bus3.ready; assign rdv[3] = bus3.rd;

  // Cycles from accept to ready for each instance (N+1).
  function automatic int lat_of(input int sel);
    case (sel)
      1:       return 3;
      2:       return 2;
      default: return 5;
    endcase
  endfunction

  // Generic shift-and-add GF(2^8) multiply used by the reference model.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] model(input logic [31:0] col, input logic e, input bit dec);
    logic [7:0]  a [4];
    logic [7:0]  c [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) a[i] = col[8*i +: 8];
    if (e || !dec) c = '{8'h02, 8'h03, 8'h01, 8'h01};
    else           c = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    r = 32'h0;
    for (int k = 0; k < 4; k++) begin
      r[8*k +: 8] = gmul(c[0], a[k]) ^ gmul(c[1], a[(k+1)%4]) ^
                    gmul(c[2], a[(k+2)%4]) ^ gmul(c[3], a[(k+3)%4]);
    end
    return r;
  endfunction

  task automatic cycle();
    @(posedge g_clk);
    #1;
  endtask

  task automatic end_op();
    cycle();
    valid = 1'b0;
    cycle();
    cycle();
  endtask

  // Issues one request and waits (bounded) for ready on instance sel.
  // lat = -1 when no ready arrives in time.
  task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic e, input bit scramble,
                        output int lat, output logic [31:0] res);
    rs1   = a;
    rs2   = b;
    enc   = e;
    valid = 1'b1;
    lat   = -1;
    res   = 32'h0;
    for (int c = 0; c < 12; c++) begin
      @(negedge g_clk);
      if (rdy[sel]) begin
        lat = c;
        res = rdv[sel];
        break;
      end
      cycle();
      if (scramble) begin
        rs1 = $urandom;
        rs2 = $urandom;
        enc = 1'($urandom);
      end
    end
    end_op();
  endtask

  task automatic test_reset();
    #2;
    for (int s = 0; s < 4; s++) begin
      vectors++;
      if (rdy[s] !== 1'b0) begin
        $display("[TB] FAIL reset_ready[%0d] got %b want 0", s, rdy[s]);
        errors++;
      end
      vectors++;
      if (rdv[s] !== 32'h0) begin
        $display("[TB] FAIL reset_rd[%0d] got %h want 00000000", s, rdv[s]);
        errors++;
      end
    end
    #10 g_resetn = 1'b1;
    cycle();
    cycle();
  endtask

  task automatic test_forward();
    int lat;
    logic [31:0] res;
    run_op(0, 32'h000013db, 32'h45530000, 1'b1, 1'b0, lat, res);
    vectors++;
    if (lat !== 5) begin
      $display("[TB] FAIL fwd_latency got %0d want 5", lat);
      errors++;
    end
    vectors++;
    if (res !== 32'hbca14d8e) begin
      $display("[TB] FAIL fwd_rd got %h want bca14d8e", res);
      errors++;
    end
  endtask

  task automatic test_inverse();
    int lat;
    logic [31:0] res;
    run_op(1, 32'h00004d8e, 32'hbca10000, 1'b0, 1'b0, lat, res);
    vectors++;
    if (lat !== 3) begin
      $display("[TB] FAIL inv_latency got %0d want 3", lat);
      errors++;
    end
    vectors++;
    if (res !== 32'h455313db) begin
      $display("[TB] FAIL inv_rd_a got %h want 455313db", res);
      errors++;
    end
    run_op(1, 32'h0000dc9f, 32'h9d580000, 1'b0, 1'b0, lat, res);
    vectors++;
    if (res !== 32'h5c220af2) begin
      $display("[TB] FAIL inv_rd_b got %h want 5c220af2", res);
      errors++;
    end
  endtask

  // Unused source bits carry junk to show they are ignored.
  task automatic test_fixed_points();
    int lat;
    logic [31:0] res;
    logic [31:0] cols [2];
    cols = '{32'h01010101, 32'hc6c6c6c6};
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 2; i++) begin
        run_op(2, {16'hdead, cols[i][15:0]}, {cols[i][31:16], 16'hbeef},
               1'(m), 1'b0, lat, res);
        vectors++;
        if (lat !== 2) begin
          $display("[TB] FAIL fixed_latency enc=%0d got %0d want 2", m, lat);
          errors++;
        end
        vectors++;
        if (res !== cols[i]) begin
          $display("[TB] FAIL fixed_rd enc=%0d got %h want %h", m, res, cols[i]);
          errors++;
        end
      end
    end
  endtask

  task automatic test_stability();
    int lat;
    logic [31:0] res;
    run_op(0, 32'h00000af2, 32'h5c220000, 1'b1, 1'b1, lat, res);
    vectors++;
    if (res !== 32'h9d58dc9f) begin
      $display("[TB] FAIL stable_rd got %h want 9d58dc9f", res);
      errors++;
    end
  endtask

  task automatic test_abort();
    int lat;
    logic [31:0] res;
    rs1   = 32'h000013db;
    rs2   = 32'h45530000;
    enc   = 1'b1;
    valid = 1'b1;
    cycle();
    cycle();
    valid = 1'b0;
    @(negedge g_clk);
    vectors++;
    if (rdy[0] !== 1'b0) begin
      $display("[TB] FAIL abort_ready got %b want 0", rdy[0]);
      errors++;
    end
    cycle();
    run_op(0, 32'h00000af2, 32'h5c220000, 1'b1, 1'b0, lat, res);
    vectors++;
    if (lat !== 5) begin
      $display("[TB] FAIL abort_next_latency got %0d want 5", lat);
      errors++;
    end
    vectors++;
    if (res !== 32'h9d58dc9f) begin
      $display("[TB] FAIL abort_next_rd got %h want 9d58dc9f", res);
      errors++;
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] res;
    rs1   = 32'h000013db;
    rs2   = 32'h45530000;
    enc   = 1'b1;
    valid = 1'b1;
    cycle();
    cycle();
    g_resetn = 1'b0;
    valid    = 1'b0;
    #1;
    vectors++;
    if (rdy[0] !== 1'b0) begin
      $display("[TB] FAIL midreset_ready got %b want 0", rdy[0]);
      errors++;
    end
    vectors++;
    if (rdv[0] !== 32'h0) begin
      $display("[TB] FAIL midreset_rd got %h want 00000000", rdv[0]);
      errors++;
    end
    #2 g_resetn = 1'b1;
    cycle();
    run_op(0, 32'h000013db, 32'h45530000, 1'b1, 1'b0, lat, res);
    vectors++;
    if (lat !== 5) begin
      $display("[TB] FAIL postreset_latency got %0d want 5", lat);
      errors++;
    end
    vectors++;
    if (res !== 32'hbca14d8e) begin
      $display("[TB] FAIL postreset_rd got %h want bca14d8e", res);
      errors++;
    end
  endtask

  task automatic test_dec_disabled();
    int lat;
    logic [31:0] res;
    run_op(3, 32'h000013db, 32'h45530000, 1'b0, 1'b0, lat, res);
    vectors++;
    if (res !== 32'hbca14d8e) begin
      $display("[TB] FAIL nodec_rd got %h want bca14d8e", res);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    int first;
    int second;
    for (int sel = 1; sel < 3; sel++) begin
      first  = -1;
      second = -1;
      rs1    = 32'h000013db;
      rs2    = 32'h45530000;
      enc    = 1'b1;
      valid  = 1'b1;
      for (int c = 0; c < 30; c++) begin
        @(negedge g_clk);
        if (rdy[sel]) begin
          vectors++;
          if (rdv[sel] !== 32'hbca14d8e) begin
            $display("[TB] FAIL b2b_rd[%0d] got %h want bca14d8e", sel, rdv[sel]);
            errors++;
          end
          if (first < 0) begin
            first = c;
          end else begin
            second = c;
            break;
          end
        end
        cycle();
      end
      end_op();
      vectors++;
      if (first !== lat_of(sel)) begin
        $display("[TB] FAIL b2b_first[%0d] got %0d want %0d", sel, first, lat_of(sel));
        errors++;
      end
      vectors++;
      if (second - first !== lat_of(sel) + 1) begin
        $display("[TB] FAIL b2b_interval[%0d] got %0d want %0d", sel, second - first, lat_of(sel) + 1);
        errors++;
      end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] res;
    logic [31:0] col;
    logic [31:0] exp;
    logic        e;
    for (int sel = 0; sel < 4; sel++) begin
      for (int j = 0; j < 4; j++) begin
        col = $urandom;
        e   = 1'($urandom);
        exp = model(col, e, sel != 3);
        run_op(sel, {16'($urandom), col[15:0]}, {col[31:16], 16'($urandom)},
               e, 1'b0, lat, res);
        vectors++;
        if (lat !== lat_of(sel)) begin
          $display("[TB] FAIL rand_latency[%0d] got %0d want %0d", sel, lat, lat_of(sel));
          errors++;
        end
        vectors++;
        if (res !== exp) begin
          $display("[TB] FAIL rand_rd[%0d] col=%h enc=%b got %h want %h", sel, col, e, res, exp);
          errors++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_fixed_points();
    test_stability();
    test_abort();
    test_reset_mid();
    test_dec_disabled();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
